// File: rtl/cpu_pkg.sv
// Constants and types shared between the CPU register file and its companions.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int CPU_W = 8;
  localparam int CPU_D = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// Walks a register-file address range through one read port and emits each
// captured register as a byte on a valid/ready stream.
`timescale 1ns/1ps
module reg_dump
  import cpu_pkg::*;
#(
  parameter int W = CPU_W,
  parameter int D = CPU_D
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D-1:0] FirstAddr,
  input  logic [D-1:0] LastAddr,
  output logic [D-1:0] RaddrOut,
  input  logic [W-1:0] RdataIn,
  output logic [W-1:0] OutData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         Busy,
  output logic         Done
);

  localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};

  dump_state_t  state_reg;
  logic [D-1:0] addr_reg;
  logic [D-1:0] last_reg;

  // The read port always follows the walking address; it is parked at 0 in IDLE.
  assign RaddrOut = addr_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      last_reg  <= '0;
      OutData   <= '0;
      OutValid  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            addr_reg  <= FirstAddr;
            last_reg  <= LastAddr;
            Busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // Snapshot: the byte is frozen here, later register writes cannot reach it.
          OutData   <= RdataIn;
          OutValid  <= 1'b1;
          state_reg <= SEND;
        end
        SEND: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            if (addr_reg == last_reg) begin
              Done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              addr_reg  <= addr_reg + ADDR_ONE;
              state_reg <= LOAD;
            end
          end
        end
        DONE: begin
          Done      <= 1'b0;
          Busy      <= 1'b0;
          addr_reg  <= '0;
          OutData   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a table of address ranges plus hand-written
// sequences for backpressure, snapshot and mid-dump reset.
`timescale 1ns/1ps
module tb_reg_dump;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [2:0] FirstAddr;
  logic [2:0] LastAddr;
  logic [2:0] RaddrOut;
  logic [7:0] RdataIn;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady;
  logic       Busy;
  logic       Done;

  logic [7:0] rf [8];
  int tests = 0;
  int fails = 0;

  assign RdataIn = rf[RaddrOut];

  reg_dump #(.W(8), .D(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .FirstAddr(FirstAddr), .LastAddr(LastAddr),
    .RaddrOut(RaddrOut), .RdataIn(RdataIn),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  first;
    logic [2:0]  last;
    int          n;
    logic [63:0] exp;   // expected bytes, first byte in the low octet
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_dump(input int vi, input logic [2:0] first, input logic [2:0] last,
                          input int n, input logic [63:0] exp);
    int got = 0;
    int dones = 0;
    int last_hs = -1;
    int cyc = 0;
    bit fin = 0;
    FirstAddr = first;
    LastAddr  = last;
    OutReady  = 1'b1;
    Start     = 1'b1;
    step();
    Start     = 1'b0;
    FirstAddr = ~first;
    LastAddr  = ~last;
    check("busy_after_start", 64'(Busy), 64'd1);
    check("valid_in_load", 64'(OutValid), 64'd0);
    while (!fin && cyc < 200) begin
      if (OutValid && OutReady) begin
        $display("[TB] vec %0d byte %0d = %02h", vi, got, OutData);
        if (got < 8) check("byte", 64'(OutData), 64'(exp[8*got +: 8]));
        check("hs_spacing", 64'(cyc - last_hs), 64'd2);
        last_hs = cyc;
        got++;
      end
      if (Done) begin
        dones++;
        check("busy_in_done", 64'(Busy), 64'd1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("done_one_cycle", 64'(Done), 64'd0);
        check("busy_after_done", 64'(Busy), 64'd0);
        fin = 1;
      end else begin
        step();
        cyc++;
      end
    end
    check("dump_finished", 64'(fin), 64'd1);
    check("byte_count", 64'(got), 64'(n));
    check("done_pulses", 64'(dones), 64'd1);
  endtask

  initial begin
    vecs[0] = '{first: 3'd0, last: 3'd7, n: 8, exp: 64'h7766554433221100};
    vecs[1] = '{first: 3'd6, last: 3'd1, n: 4, exp: 64'h0000000011007766};
    vecs[2] = '{first: 3'd5, last: 3'd5, n: 1, exp: 64'h0000000000000055};
    vecs[3] = '{first: 3'd7, last: 3'd0, n: 2, exp: 64'h0000000000000077};
    vecs[4] = '{first: 3'd3, last: 3'd4, n: 2, exp: 64'h0000000000004433};

    for (int i = 0; i < 8; i++) rf[i] = 8'(8'h11 * i);
    Start = 1'b0; FirstAddr = '0; LastAddr = '0; OutReady = 1'b0;
    Reset = 1'b1;
    #1;
    check("rst_valid", 64'(OutValid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_raddr", 64'(RaddrOut), 64'd0);
    check("rst_data", 64'(OutData), 64'd0);
    step(); step();
    Reset = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      run_dump(v, vecs[v].first, vecs[v].last, vecs[v].n, vecs[v].exp);
      step();
    end

    // Backpressure: range 2..3 with the consumer stalled for 5 cycles.
    FirstAddr = 3'd2; LastAddr = 3'd3; OutReady = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(OutValid), 64'd1);
      check("bp_data", 64'(OutData), 64'h22);
      check("bp_raddr", 64'(RaddrOut), 64'd2);
      step();
    end
    OutReady = 1'b1;
    check("bp_first", 64'(OutData), 64'h22);
    $display("[TB] backpressure byte 0 = %02h", OutData);
    step();
    check("bp_valid_drop", 64'(OutValid), 64'd0);
    step();
    check("bp_second_valid", 64'(OutValid), 64'd1);
    check("bp_second", 64'(OutData), 64'h33);
    $display("[TB] backpressure byte 1 = %02h", OutData);
    step();
    check("bp_done", 64'(Done), 64'd1);
    check("bp_no_dup", 64'(OutValid), 64'd0);
    step();
    check("bp_idle", 64'(Busy), 64'd0);
    step();

    // Snapshot: register 3 rewritten in the cycle after capture.
    FirstAddr = 3'd3; LastAddr = 3'd3; OutReady = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    check("snap_raddr", 64'(RaddrOut), 64'd3);
    step();
    rf[3] = 8'hAB;
    step();
    check("snap_data", 64'(OutData), 64'h33);
    OutReady = 1'b1;
    $display("[TB] snapshot byte = %02h", OutData);
    step();
    check("snap_done", 64'(Done), 64'd1);
    rf[3] = 8'h33;
    step(); step();

    // Reset asserted between edges during SEND aborts the dump.
    FirstAddr = 3'd0; LastAddr = 3'd7; OutReady = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    step();
    check("abort_valid_pre", 64'(OutValid), 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("abort_valid", 64'(OutValid), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    step();
    check("abort_no_done", 64'(Done), 64'd0);
    Reset = 1'b0;
    step();
    check("abort_idle", 64'(Busy), 64'd0);
    run_dump(9, 3'd0, 3'd0, 1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
